// File: rtl/block_window_loader_pkg.sv
// Shared types for the block window loader: window size, field widths,
// the per-slot record and the loader state encoding.
package block_window_loader_pkg;

  localparam int WIN_SLOTS = 12;
  localparam int X_W       = 12;
  localparam int Y_W       = 12;
  localparam int Z_W       = 14;
  localparam int DIR_W     = 3;
  localparam int ID_W      = 8;
  localparam int T_W       = 18;
  localparam int FILL_W    = $clog2(WIN_SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    COMMIT
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [Z_W-1:0]   z;
    logic             color;
    logic [DIR_W-1:0] direction;
    logic [ID_W-1:0]  id;
    logic             visible;
  } slot_t;

  // Builds an occupied slot from a returned memory word.
  function automatic slot_t make_slot(
    input logic [X_W-1:0]   x,
    input logic [Y_W-1:0]   y,
    input logic [Z_W-1:0]   z,
    input logic             color,
    input logic [DIR_W-1:0] direction,
    input logic [ID_W-1:0]  id
  );
    slot_t s;
    s.x         = x;
    s.y         = y;
    s.z         = z;
    s.color     = color;
    s.direction = direction;
    s.id        = id;
    s.visible   = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/block_window_loader_if.sv
// Read port of the z-sorted block memory: address out, block record back
// a fixed number of cycles later.
interface block_window_loader_if
  import block_window_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] mem_addr_out;
  logic [X_W-1:0]    mem_x_in;
  logic [Y_W-1:0]    mem_y_in;
  logic [Z_W-1:0]    mem_z_in;
  logic              mem_color_in;
  logic [DIR_W-1:0]  mem_direction_in;

  modport master (
    output mem_addr_out,
    input  mem_x_in,
    input  mem_y_in,
    input  mem_z_in,
    input  mem_color_in,
    input  mem_direction_in
  );

  modport slave (
    input  mem_addr_out,
    output mem_x_in,
    output mem_y_in,
    output mem_z_in,
    output mem_color_in,
    output mem_direction_in
  );

endinterface

// File: rtl/block_z_window_check.sv
// Classifies a returned block depth against the camera window:
// inside the window, or already past its far edge.
module block_z_window_check
  import block_window_loader_pkg::*;
#(
  parameter logic [Z_W-1:0] DEPTH_RANGE = 14'd2048
) (
  input  logic [Z_W-1:0] z,
  input  logic [Z_W-1:0] cam_z,
  output logic           qualify,
  output logic           too_far
);

  logic [Z_W-1:0] dz;
  logic [Z_W:0]   far_edge;

  // dz only matters when z >= cam_z, so the 14-bit difference cannot wrap.
  assign dz       = z - cam_z;
  assign far_edge = {1'b0, cam_z} + {1'b0, DEPTH_RANGE};
  assign qualify  = (z >= cam_z) && (dz < DEPTH_RANGE);
  assign too_far  = ({1'b0, z} >= far_edge);

endmodule

// File: rtl/block_window_loader.sv
// Scans the z-sorted block memory into a 12-slot shadow bank, then swaps it
// into the active bank at a downstream safe point.
module block_window_loader
  import block_window_loader_pkg::*;
#(
  parameter int             NUM_BLOCKS  = 256,
  parameter int             ADDR_W      = 8,
  parameter int             MEM_LATENCY = 2,
  parameter logic [Z_W-1:0] DEPTH_RANGE = 14'd2048
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               refresh_in,
  input  logic [T_W-1:0]                     curr_time_in,
  input  logic [Z_W-1:0]                     cam_z_in,
  input  logic                               swap_ok_in,
  block_window_loader_if.master              mem,
  output logic [WIN_SLOTS-1:0][X_W-1:0]      block_x_out,
  output logic [WIN_SLOTS-1:0][Y_W-1:0]      block_y_out,
  output logic [WIN_SLOTS-1:0][Z_W-1:0]      block_z_out,
  output logic [WIN_SLOTS-1:0]               block_color_out,
  output logic [WIN_SLOTS-1:0][DIR_W-1:0]    block_direction_out,
  output logic [WIN_SLOTS-1:0][ID_W-1:0]     block_ID_out,
  output logic [WIN_SLOTS-1:0]               block_visible_out,
  output logic [T_W-1:0]                     curr_time_out,
  output logic                               busy_out,
  output logic                               commit_out
);

  state_t                             state;
  state_t                             state_nx;
  logic [ADDR_W-1:0]                  addr_q;
  logic                               issue_done;
  logic [Z_W-1:0]                     cam_z_q;
  logic [T_W-1:0]                     time_q;
  logic [FILL_W-1:0]                  fill_cnt;
  logic [MEM_LATENCY-1:0]             vld_pipe;
  logic [MEM_LATENCY-1:0][ADDR_W-1:0] tag_pipe;
  slot_t [WIN_SLOTS-1:0]              shadow;
  slot_t [WIN_SLOTS-1:0]              active;

  logic              ret_vld;
  logic [ADDR_W-1:0] ret_tag;
  logic              qualify;
  logic              too_far;
  logic              last_ret;
  logic              accept;
  logic              issue;
  logic              wr_en;
  logic              stop;
  logic              swap;
  slot_t             wr_slot;

  assign mem.mem_addr_out = addr_q;
  assign ret_vld          = vld_pipe[MEM_LATENCY-1];
  assign ret_tag          = tag_pipe[MEM_LATENCY-1];

  block_z_window_check #(
    .DEPTH_RANGE (DEPTH_RANGE)
  ) u_zchk (
    .z       (mem.mem_z_in),
    .cam_z   (cam_z_q),
    .qualify (qualify),
    .too_far (too_far)
  );

  assign wr_slot = make_slot(mem.mem_x_in, mem.mem_y_in, mem.mem_z_in,
                             mem.mem_color_in, mem.mem_direction_in,
                             ID_W'(ret_tag));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)            state_nx = FETCH;
      FETCH:   if (stop)              state_nx = DRAIN;
      DRAIN:   if (vld_pipe == '0)    state_nx = COMMIT;
      COMMIT:  if (swap)              state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // A qualifying word that also triggers a stop is still written; the stop
  // only suppresses further address issue.
  always_comb begin
    busy_out = (state != IDLE);
    accept   = (state == IDLE) && refresh_in;
    last_ret = ret_vld && (ret_tag == ADDR_W'(NUM_BLOCKS - 1));
    wr_en    = (state == FETCH) && ret_vld && qualify &&
               (fill_cnt < FILL_W'(WIN_SLOTS));
    stop     = (state == FETCH) &&
               ((wr_en && (fill_cnt == FILL_W'(WIN_SLOTS - 1))) ||
                (ret_vld && too_far) || last_ret);
    issue    = (state == FETCH) && !stop && !issue_done;
    swap     = (state == COMMIT) && swap_ok_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q        <= '0;
      issue_done    <= 1'b0;
      cam_z_q       <= '0;
      time_q        <= '0;
      fill_cnt      <= '0;
      vld_pipe      <= '0;
      tag_pipe      <= '0;
      curr_time_out <= '0;
      commit_out    <= 1'b0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= addr_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (accept) begin
        cam_z_q    <= cam_z_in;
        time_q     <= curr_time_in;
        fill_cnt   <= '0;
        issue_done <= 1'b0;
        addr_q     <= '0;
      end else if (issue) begin
        // The last address is issued once; the counter parks instead of wrapping.
        if (addr_q == ADDR_W'(NUM_BLOCKS - 1)) issue_done <= 1'b1;
        else                                   addr_q     <= addr_q + ADDR_W'(1);
      end
      if (wr_en) fill_cnt <= fill_cnt + FILL_W'(1);
      if (swap)  curr_time_out <= time_q;
      commit_out <= swap;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shadow <= '0;
      active <= '0;
    end else begin
      for (int s = 0; s < WIN_SLOTS; s++) begin
        if (accept)
          shadow[s].visible <= 1'b0;
        else if (wr_en && (fill_cnt == FILL_W'(s)))
          shadow[s] <= wr_slot;
      end
      if (swap) active <= shadow;
    end
  end

  for (genvar s = 0; s < WIN_SLOTS; s++) begin : g_out
    assign block_x_out[s]         = active[s].x;
    assign block_y_out[s]         = active[s].y;
    assign block_z_out[s]         = active[s].z;
    assign block_color_out[s]     = active[s].color;
    assign block_direction_out[s] = active[s].direction;
    assign block_ID_out[s]        = active[s].id;
    assign block_visible_out[s]   = active[s].visible;
  end

endmodule
